// File: rtl/add_round_key_ks_pkg.sv
`default_nettype none
// ============================================================================
// Module : add_round_key_ks_pkg
// Brief  : Shared AES constants: round count, rcon sequence and S-box lookup.
// Rev    : 1.0  initial release
// ============================================================================
package add_round_key_ks_pkg;

    localparam int NR_128 = 10;

    // rcon bytes for rounds 0..9, round 0 in the most significant byte
    localparam logic [79:0] RCON_TABLE = 80'h01_02_04_08_10_20_40_80_1b_36;

    // S-box entries with index 0x00 in the most significant byte
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] aes_sbox(input logic [7:0] b);
        return SBOX_TABLE[2047 - 8 * int'(b) -: 8];
    endfunction

    function automatic logic [7:0] aes_rcon(input logic [3:0] r);
        logic [7:0] v;
        v = 8'h00;
        if (r < 4'd10) begin
            v = RCON_TABLE[79 - 8 * int'(r) -: 8];
        end
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_key_step.sv
`default_nettype none
// ============================================================================
// Module : aes_key_step
// Brief  : Combinational AES-128 key expansion step, one round key to the next.
// Rev    : 1.0  initial release
// ============================================================================
module aes_key_step
    import add_round_key_ks_pkg::*;
(
    input  logic [127:0] rk_i,
    input  logic [7:0]   rcon_i,
    output logic [127:0] rk_next_o
);

    logic [31:0] w_w0;
    logic [31:0] w_w1;
    logic [31:0] w_w2;
    logic [31:0] w_w3;
    logic [31:0] w_rot;
    logic [31:0] w_t;
    logic [31:0] w_n0;
    logic [31:0] w_n1;
    logic [31:0] w_n2;
    logic [31:0] w_n3;

    assign {w_w0, w_w1, w_w2, w_w3} = rk_i;

    // RotWord moves the top byte of w3 to the bottom
    assign w_rot = {w_w3[23:0], w_w3[31:24]};

    assign w_t = {aes_sbox(w_rot[31:24]) ^ rcon_i,
                  aes_sbox(w_rot[23:16]),
                  aes_sbox(w_rot[15:8]),
                  aes_sbox(w_rot[7:0])};

    assign w_n0 = w_w0 ^ w_t;
    assign w_n1 = w_w1 ^ w_n0;
    assign w_n2 = w_w2 ^ w_n1;
    assign w_n3 = w_w3 ^ w_n2;

    assign rk_next_o = {w_n0, w_n1, w_n2, w_n3};

endmodule
`default_nettype wire

// File: rtl/add_round_key_ks.sv
`default_nettype none
// ============================================================================
// Module : add_round_key_ks
// Brief  : AddRoundKey stage with in-place AES-128 round-key advance.
// Rev    : 1.0  initial release
// ============================================================================
module add_round_key_ks
    import add_round_key_ks_pkg::*;
#(
    parameter int NR    = NR_128,
    parameter int KEY_W = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_load,
    input  logic [KEY_W-1:0] key_in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [KEY_W-1:0] in_state,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [KEY_W-1:0] out_state,
    output logic [3:0]       out_round,
    output logic             out_last,
    output logic             key_ok
);

    localparam logic [3:0] c_last_round = 4'(NR);

    logic [KEY_W-1:0] key_q,       key_d;
    logic [KEY_W-1:0] rk_q,        rk_d;
    logic [3:0]       round_q,     round_d;
    logic             key_ok_q,    key_ok_d;
    logic             out_valid_q, out_valid_d;
    logic [KEY_W-1:0] out_state_q, out_state_d;
    logic [3:0]       out_round_q, out_round_d;
    logic             out_last_q,  out_last_d;

    logic [KEY_W-1:0] w_rk_next;
    logic             w_accept;
    logic             w_at_last;

    aes_key_step u_key_step (
        .rk_i      (rk_q),
        .rcon_i    (aes_rcon(round_q)),
        .rk_next_o (w_rk_next)
    );

    assign in_ready  = key_ok_q & ~key_load & (~out_valid_q | out_ready);
    assign w_accept  = in_valid & in_ready;
    assign w_at_last = (round_q == c_last_round);

    always_comb begin
        key_d       = key_q;
        rk_d        = rk_q;
        round_d     = round_q;
        key_ok_d    = key_ok_q;
        out_valid_d = out_valid_q;
        out_state_d = out_state_q;
        out_round_d = out_round_q;
        out_last_d  = out_last_q;

        if (key_load) begin
            key_d       = key_in;
            rk_d        = key_in;
            round_d     = 4'd0;
            key_ok_d    = 1'b1;
            out_valid_d = 1'b0;
        end else if (w_accept) begin
            out_valid_d = 1'b1;
            out_state_d = in_state ^ rk_q;
            out_round_d = round_q;
            out_last_d  = w_at_last;
            // After the final round the schedule rewinds to the stored cipher key
            if (w_at_last) begin
                rk_d    = key_q;
                round_d = 4'd0;
            end else begin
                rk_d    = w_rk_next;
                round_d = round_q + 4'd1;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            key_q       <= '0;
            rk_q        <= '0;
            round_q     <= 4'd0;
            key_ok_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_state_q <= '0;
            out_round_q <= 4'd0;
            out_last_q  <= 1'b0;
        end else begin
            key_q       <= key_d;
            rk_q        <= rk_d;
            round_q     <= round_d;
            key_ok_q    <= key_ok_d;
            out_valid_q <= out_valid_d;
            out_state_q <= out_state_d;
            out_round_q <= out_round_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_state = out_state_q;
    assign out_round = out_round_q;
    assign out_last  = out_last_q;
    assign key_ok    = key_ok_q;

endmodule
`default_nettype wire
